axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. It is the next-generation replacement for the fixed four-register slave in the PMOD peripheral IPs.
- Adds the following:
  - configurable register count and data width;
  - per-register read-only mask, with RO registers fed by hardware status inputs;
  - WSTRB byte enables;
  - SLVERR on out-of-range addresses;
  - AW and W accepted independently, in either order;
  - a per-register write pulse for downstream logic.
- Sits between the AXI interconnect and the peripheral core, such as the SPI accelerometer controller.

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64.
- NUM_REGS, 8, number of word registers; 1 to 64.
- ADDR_WIDTH, 8, AXI address width; must be at least ADDR_LSB + clog2(NUM_REGS).
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only, sourced from hw_status.

Ports:
- The interface has one clock. Reset is synchronous and active-low. Clock and reset are named S_AXI_ACLK and S_AXI_ARESETN, as in the codebase's AXI slaves.
- S_AXI_ACLK in 1 clock
- S_AXI_ARESETN in 1 synchronous active-low reset
- S_AXI_AWADDR in ADDR_WIDTH write address
- S_AXI_AWPROT in 3 ignored
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1 write address handshake
- S_AXI_WDATA in DATA_WIDTH write data
- S_AXI_WSTRB in DATA_WIDTH/8 byte enables
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1 write data handshake
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1 write response
- S_AXI_ARADDR in ADDR_WIDTH read address
- S_AXI_ARPROT in 3 ignored
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1 read address handshake
- S_AXI_RDATA out DATA_WIDTH / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1 read data
- reg_q out NUM_REGS*DATA_WIDTH flattened register contents; register i is at [i*DW +: DW]
- hw_status in NUM_REGS*DATA_WIDTH values returned for RO registers; RW slices are unused
- wr_pulse out NUM_REGS one-cycle pulse per register written

Behaviour:
- Address decoding:
  - ADDR_LSB = clog2(DATA_WIDTH/8).
  - Register index = addr >> ADDR_LSB. Byte-offset bits are ignored.
  - An index >= NUM_REGS is out of range.
- Reset (ARESETN = 0 at a rising edge):
  - All RW registers, outputs and FSMs go to 0 or idle: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP = 00; RDATA = 0; wr_pulse = 0.
  - Ready signals rise on the first edge after ARESETN = 1.
  - Reset mid-transaction abandons the transaction. No partial write is committed and no response is issued.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY and WREADY are each high until their own beat is captured, then low. The two beats may complete in the same cycle or in either order.
  - In the cycle after both beats are held, the write commits:
    - RW in range: each byte with WSTRB set is updated; wr_pulse[i] = 1 for one cycle, even when WSTRB = 0.
    - RO register: data is discarded, BRESP = OKAY, no pulse.
    - Out of range: nothing is written, BRESP = SLVERR (10).
  - In the same commit cycle, BVALID is set and the FSM moves to W_RESP.
  - W_RESP holds BVALID and BRESP stable until BREADY. It then returns to W_IDLE with AWREADY and WREADY re-raised on the next edge.
  - One write is outstanding at a time.
- Read FSM, states R_IDLE, R_DATA:
  - ARREADY = 1 in R_IDLE.
  - The AR handshake edge registers RDATA and RRESP and sets RVALID. Latency is 1 cycle.
  - RDATA source:
    - RO: the hw_status slice.
    - RW: the current register value.
    - Out of range: 0 with RRESP = SLVERR.
  - R_DATA holds RDATA, RRESP and RVALID stable until RREADY, then returns to R_IDLE.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- The read and write paths are fully independent. Both may be active concurrently.
- VALID from the master may be held across stall cycles. The slave never drops RVALID or BVALID before the handshake.

Decomposition:
- Package axil_regbank_pkg holds:
  - the resp_t enum (OKAY = 00, SLVERR = 10);
  - the wstate_t and rstate_t enums;
  - a clog2 helper function.
- Natural sub-module: axil_regbank_reg, a single DATA_WIDTH register with byte-enable write and a wr_pulse output. It is instantiated NUM_REGS times through a generate loop that also applies RO_MASK.

Test Plan:
- Defaults, RO_MASK = 0: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back -> data matches, BRESP and RRESP = 00, wr_pulse[0..3] each pulse once.
- Byte strobes: write 0xAABBCCDD to 0x10 with WSTRB = 1111, then 0x11223344 with WSTRB = 0101 -> read returns 0xAA22CC44.
- W before AW: WVALID asserted 3 cycles ahead of AWVALID to address 0x14 with 0x5A5A5A5A -> WREADY drops after the W beat, a single BVALID follows, read back returns 0x5A5A5A5A.
- RO_MASK = 0x80, hw_status[7] = 0xDEADBEEF: write 0x1 to 0x1C -> BRESP = 00, wr_pulse[7] stays 0; read 0x1C -> 0xDEADBEEF.
- Out of range, NUM_REGS = 8: write or read address 0x20 -> BRESP = 10 and RRESP = 10, RDATA = 0, no register changes.
- Backpressure and reset: hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and data stay stable. Then assert ARESETN = 0 mid-write -> all outputs are 0 on the next edge and all registers read 0 after reset.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, FSM states
// and a constant-foldable clog2 used for address decoding.
package axil_regbank_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register
// bank (slave); clock and reset stay outside as plain ports.
interface axil_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axil_regbank_reg.sv
// One read/write word register with per-byte write enables; wr_pulse marks
// the cycle after a commit, whether or not any byte strobe was set.
module axil_regbank_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_sys,
    input  logic                    rst_b,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    wr_pulse
);

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            q        <= '0;
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_en;
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_en && wr_strb[b]) begin
                    q[b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with read-only status slots,
// byte strobes, SLVERR decode and a per-register write pulse.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (any order); commits once both are held
// W_RESP | BVALID/BRESP held until BREADY
// R_IDLE | ARREADY high, AR handshake registers RDATA/RRESP
// R_DATA | RVALID/RDATA/RRESP held until RREADY
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    axil_regbank_if.slave                  s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = (clog2(NUM_REGS) > 0) ? clog2(NUM_REGS) : 1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'(addr >> ADDR_LSB);
    endfunction

    wstate_t                 wstate_q, wstate_n;
    logic                    aw_held_q, aw_held_n, w_held_q, w_held_n;
    logic                    awready_q, awready_n, wready_q, wready_n;
    logic                    bvalid_q, bvalid_n;
    resp_t                   bresp_q, bresp_n;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
    logic                    commit;

    rstate_t                 rstate_q, rstate_n;
    logic                    arready_q, arready_n, rvalid_q, rvalid_n;
    resp_t                   rresp_q, rresp_n;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;

    logic [NUM_REGS-1:0]     wr_en;
    logic [DATA_WIDTH-1:0]   rd_src [NUM_REGS];
    logic                    unused_ok;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wstate_q  <= wstate_n;
            aw_held_q <= aw_held_n;
            w_held_q  <= w_held_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
        end
    end

    always_comb begin
        wstate_n  = wstate_q;
        aw_held_n = aw_held_q;
        w_held_n  = w_held_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        commit    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    commit    = 1'b1;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    bvalid_n  = 1'b1;
                    bresp_n   = in_range(waddr_q) ? RESP_OKAY : RESP_SLVERR;
                    wstate_n  = W_RESP;
                end else begin
                    if (awready_q && s_axi.S_AXI_AWVALID) begin
                        aw_held_n = 1'b1;
                        waddr_n   = s_axi.S_AXI_AWADDR;
                    end
                    if (wready_q && s_axi.S_AXI_WVALID) begin
                        w_held_n = 1'b1;
                        wdata_n  = s_axi.S_AXI_WDATA;
                        wstrb_n  = s_axi.S_AXI_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_n = 1'b0;
                    wstate_n = W_IDLE;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
        // Readies are registered so they stay low through reset and rise one edge later.
        awready_n = (wstate_n == W_IDLE) && !aw_held_n;
        wready_n  = (wstate_n == W_IDLE) && !w_held_n;
    end

    always_comb begin
        wr_en = '0;
        if (commit && in_range(waddr_q)) begin
            wr_en[reg_index(waddr_q)] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign rd_src[i]   = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
            assign wr_pulse[i] = 1'b0;
        end else begin : g_rw
            axil_regbank_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_reg (
                .clk_sys  (S_AXI_ACLK),
                .rst_b    (S_AXI_ARESETN),
                .wr_en    (wr_en[i]),
                .wr_data  (wdata_q),
                .wr_strb  (wstrb_q),
                .q        (rd_src[i]),
                .wr_pulse (wr_pulse[i])
            );
        end
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = rd_src[i];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

    // rd_src is sampled before this edge's write lands, so a colliding read sees the old value.
    always_comb begin
        rstate_n = rstate_q;
        rvalid_n = rvalid_q;
        rresp_n  = rresp_q;
        rdata_n  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && s_axi.S_AXI_ARVALID) begin
                    rvalid_n = 1'b1;
                    rstate_n = R_DATA;
                    if (in_range(s_axi.S_AXI_ARADDR)) begin
                        rdata_n = rd_src[reg_index(s_axi.S_AXI_ARADDR)];
                        rresp_n = RESP_OKAY;
                    end else begin
                        rdata_n = '0;
                        rresp_n = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_n = 1'b0;
                    rstate_n = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
        arready_n = (rstate_n == R_IDLE);
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    // PROT is ignored; RW slices of hw_status and RO write enables have no sink.
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, hw_status, wr_en};

endmodule

// File: tb/tb_axil_regbank.sv
// Scoreboard bench for axil_regbank: stimulus pushes expected B/R responses and
// write pulses into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axil_regbank;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 8;
    localparam logic [NR-1:0] RO = 8'h80;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] hw_status;
    logic [NR-1:0]    wr_pulse;

    axil_regbank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .RO_MASK    (RO)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (arst_n),
        .s_axi         (bus),
        .reg_q         (reg_q),
        .hw_status     (hw_status),
        .wr_pulse      (wr_pulse)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [NR];
    logic [1:0]  exp_b [$];
    logic [7:0]  exp_pulse [$];
    logic [33:0] exp_r [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got nothing, expected a handshake", name);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++) begin
            if (!RO[i]) check(name, 64'(reg_q[i*DW +: DW]), 64'(model[i]));
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int bstall);
        int idx;
        int aw_start;
        int w_start;
        int cyc;
        bit aw_done;
        bit w_done;
        idx = int'(addr) / 4;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        cyc = 0;
        aw_done = 0;
        w_done = 0;
        if (idx >= NR) begin
            exp_b.push_back(SLVERR);
            exp_pulse.push_back(8'h00);
        end else if (RO[idx]) begin
            exp_b.push_back(OKAY);
            exp_pulse.push_back(8'h00);
        end else begin
            exp_b.push_back(OKAY);
            exp_pulse.push_back(8'(1 << idx));
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_start);
            bus.S_AXI_WVALID  = !w_done && (cyc >= w_start);
            @(negedge clk);
            if (w_done && !aw_done) check("wready_after_w_beat", 64'(bus.S_AXI_WREADY), 64'(0));
            if (aw_done && !w_done) check("awready_after_aw_beat", 64'(bus.S_AXI_AWREADY), 64'(0));
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) fail_now("aw_w_handshake_timeout");
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.S_AXI_BVALID && cyc < 20);
        if (!bus.S_AXI_BVALID) fail_now("bvalid_timeout");
        repeat (bstall) @(negedge clk);
        @(posedge clk);
        #1 bus.S_AXI_BREADY = 1'b1;
        @(posedge clk);
        #1 bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int rstall);
        int idx;
        int cyc;
        bit hs;
        idx = int'(addr) / 4;
        cyc = 0;
        hs = 0;
        if (idx >= NR) exp_r.push_back({32'h0, SLVERR});
        else if (RO[idx]) exp_r.push_back({hw_status[idx*DW +: DW], OKAY});
        else exp_r.push_back({model[idx], OKAY});
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!hs) fail_now("arready_timeout");
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.S_AXI_RVALID && cyc < 20);
        check("read_latency_cycles", 64'(cyc), 64'(1));
        repeat (rstall) @(negedge clk);
        @(posedge clk);
        #1 bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1 bus.S_AXI_RREADY = 1'b0;
    endtask

    // Monitor: responses, hold-under-backpressure and write pulses.
    logic        prev_bvalid = 1'b0, prev_bready = 1'b0;
    logic        prev_rvalid = 1'b0, prev_rready = 1'b0;
    logic [1:0]  prev_bresp = 2'b00;
    logic [33:0] prev_r = '0;
    logic        pulse_next = 1'b0;

    always @(negedge clk) begin
        if (arst_n) begin
            if (prev_bvalid && !prev_bready)
                check("b_hold_stable", 64'({bus.S_AXI_BVALID, bus.S_AXI_BRESP}), 64'({1'b1, prev_bresp}));
            if (prev_rvalid && !prev_rready)
                check("r_hold_stable", 64'({bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP}),
                      64'({1'b1, prev_r}));
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (exp_b.size() == 0) fail_now("unexpected_b_response");
                else check("bresp", 64'(bus.S_AXI_BRESP), 64'(exp_b.pop_front()));
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (exp_r.size() == 0) fail_now("unexpected_r_response");
                else check("rdata_rresp", 64'({bus.S_AXI_RDATA, bus.S_AXI_RRESP}), 64'(exp_r.pop_front()));
            end
            if (pulse_next) check("wr_pulse_one_cycle", 64'(wr_pulse), 64'(0));
            pulse_next = 1'b0;
            if (bus.S_AXI_BVALID && !prev_bvalid) begin
                if (exp_pulse.size() == 0) fail_now("unexpected_bvalid");
                else check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse.pop_front()));
                pulse_next = 1'b1;
            end
        end
        prev_bvalid = arst_n && bus.S_AXI_BVALID;
        prev_bready = bus.S_AXI_BREADY;
        prev_bresp  = bus.S_AXI_BRESP;
        prev_rvalid = arst_n && bus.S_AXI_RVALID;
        prev_rready = bus.S_AXI_RREADY;
        prev_r      = {bus.S_AXI_RDATA, bus.S_AXI_RRESP};
    end

    task automatic check_reset_outputs(input string name);
        check(name, 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                         bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, wr_pulse}),
              64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        for (int i = 0; i < NR; i++) begin
            hw_status[i*DW +: DW] = $urandom;
            model[i] = '0;
        end
        hw_status[7*DW +: DW] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        check_regs("reset_reg");
        @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
        check("ready_low_before_first_edge", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 64'(0));
        @(negedge clk);
        check("ready_rise_after_reset", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 64'(3'b111));
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0);

        do_write(8'h10, 32'hAABBCCDD, 4'b1111, 0, 0);
        do_write(8'h10, 32'h11223344, 4'b0101, -1, 0);
        check("strobe_merge", 64'(reg_q[4*DW +: DW]), 64'(32'hAA22CC44));
        do_read(8'h10, 0);

        do_write(8'h14, 32'h5A5A5A5A, 4'hF, 3, 0);
        do_read(8'h14, 0);

        do_write(8'h1C, 32'h00000001, 4'hF, 0, 0);
        do_read(8'h1C, 0);

        do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
        check_regs("out_of_range_no_change");
        do_read(8'h20, 0);

        do_write(8'h08, 32'hC0FFEE00, 4'hF, 0, 5);
        do_read(8'h08, 5);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] addr;
            addr = 8'($urandom_range(0, 39));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 3)));
            else
                do_read(addr, int'($urandom_range(0, 3)));
        end
        check_regs("random_regs");

        // Reset with only the AW beat captured: nothing may commit or respond.
        bus.S_AXI_AWADDR  = 8'h00;
        bus.S_AXI_AWVALID = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.S_AXI_AWREADY && cyc < 20);
        @(posedge clk);
        #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = 32'h12345678;
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_write_outputs");
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_regs("reset_mid_write_reg");
        @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) do_read(8'(i * 4), 0);

        repeat (5) @(posedge clk);
        check("b_queue_drained", 64'(exp_b.size()), 64'(0));
        check("r_queue_drained", 64'(exp_r.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
